// File: rtl/mem_pair_reader_pkg.sv
// Shared types and helpers for the mem1/mem2 lockstep read sequencer.
// Imported by the reader top and its pair FIFO.
package mem_pair_reader_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; (1 << i) < v; i++) r = i + 1;
      return (r == 0) ? 1 : r;
   endfunction

   function automatic int pair_w(input int dw);
      return 2 * dw + 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_e;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int PAIR_W = pair_w(DATA_WIDTH_DEF);

endpackage

// File: rtl/mem_pair_reader_fifo.sv
// Synchronous FIFO holding {last, a, b} pair words; depth must be a power of 2.
// Push and pop may occur together; the caller guarantees no overflow/underflow.
module pair_fifo
   import mem_pair_reader_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = PAIR_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [clog2(DEPTH+1)-1:0]  count_o,
   output logic                       empty_o
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (push_i && !pop_i) cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + PW'(1);
         end
         if (pop_i) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_d;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mem_pair_reader.sv
// Lockstep reader for mem1/mem2: issues credit-limited reads, absorbs the
// 1-cycle read latency and streams (a,b,last) pairs over valid/ready.
module mem_pair_reader
   import mem_pair_reader_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int VETOR_WIDTH = 4,
   parameter int DEPTH       = VETOR_WIDTH * DATA_WIDTH,
   parameter int ADDR_WIDTH  = clog2(DEPTH),
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en_a,
   output logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic                  rd_en_b,
   output logic [ADDR_WIDTH-1:0] rd_addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_a,
   output logic [DATA_WIDTH-1:0] m_b,
   output logic                  m_last
);

   localparam int PW = pair_w(DATA_WIDTH);
   localparam int CW = clog2(FIFO_DEPTH + 1);
   localparam int AW = ADDR_WIDTH;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   rem_q, rem_d;
   logic          infl_q, last_q;

   logic [CW-1:0] fifo_cnt;
   logic [CW:0]   used;
   logic [PW-1:0] head;
   logic          fifo_empty;
   logic          rd_en;
   logic          pop;

   // Credit: buffered pairs plus the one possibly in flight must fit.
   assign used  = {1'b0, fifo_cnt} + (CW + 1)'(infl_q);
   assign rd_en = (state_q == READ) && (used < (CW + 1)'(FIFO_DEPTH));
   assign pop   = m_valid && m_ready;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               rem_d   = len;
               state_d = (len == '0) ? FIN : READ;
            end
         end
         READ: begin
            if (rd_en) begin
               addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
               rem_d  = rem_q - (AW + 1)'(1);
               if (rem_q == (AW + 1)'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && m_last) state_d = FIN;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         infl_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         infl_q  <= rd_en;
         last_q  <= rd_en && (rem_q == (AW + 1)'(1));
      end
   end

   pair_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (infl_q),
      .din_i   ({last_q, din_a, din_b}),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty)
   );

   assign busy      = (state_q == READ) || (state_q == DRAIN);
   assign done      = (state_q == FIN);
   assign rd_en_a   = rd_en;
   assign rd_en_b   = rd_en;
   assign rd_addr_a = addr_q;
   assign rd_addr_b = addr_q;
   assign m_valid   = !fifo_empty;
   assign m_last    = head[PW-1];
   assign m_a       = head[2*DATA_WIDTH-1:DATA_WIDTH];
   assign m_b       = head[DATA_WIDTH-1:0];

endmodule
